// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared definitions for the expmul KV scheduler slice:
//     MAX_SEQ            max keys per query row (from `MAX_SEQ_LENGTH, default 8)
//     CNT_W              width of seq_len / kv index, wide enough to hold MAX_SEQ
//     EXPMUL_DIFF_IN_QT  signed score / max format fed to expmul
//     M_NEG_INIT         most-negative EXPMUL_DIFF_IN_QT, seed of the running max
//     KV_SCHED_STATE_T   scheduler FSM states {IDLE, STREAM, FLUSH}
//     clamp_seq_len()    maps an out-of-range row length into 1..MAX_SEQ
// -----------------------------------------------------------------------------
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package sys_defs;

    localparam int MAX_SEQ = `MAX_SEQ_LENGTH;
    localparam int CNT_W   = $clog2(`MAX_SEQ_LENGTH) + 1;
    localparam int DIFF_W  = 16;

    typedef logic signed [DIFF_W-1:0] EXPMUL_DIFF_IN_QT;

    localparam EXPMUL_DIFF_IN_QT M_NEG_INIT =
        EXPMUL_DIFF_IN_QT'({1'b1, {(DIFF_W-1){1'b0}}});

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } KV_SCHED_STATE_T;

    // Zero becomes a single-key row; anything above MAX_SEQ is cut to MAX_SEQ.
    function automatic logic [CNT_W-1:0] clamp_seq_len(input logic [CNT_W-1:0] len);
        if (len == '0) begin
            return CNT_W'(1);
        end
        if (len > CNT_W'(MAX_SEQ)) begin
            return CNT_W'(MAX_SEQ);
        end
        return len;
    endfunction

endpackage

// File: rtl/kv_max_tracker.sv
// -----------------------------------------------------------------------------
// kv_max_tracker
//   Running-max register for one query row plus the signed compare that forms
//   the max including the current score.
// Ports:
//   clock     in   single clock, posedge
//   reset     in   synchronous, active-high; max returns to M_NEG_INIT
//   i_init    in   start of a new row; max returns to M_NEG_INIT
//   i_update  in   a beat was accepted; max advances to o_m_next
//   i_score   in   score of the beat being offered
//   o_m_run   out  max of all beats accepted so far in this row
//   o_m_next  out  max(o_m_run, i_score), signed
// -----------------------------------------------------------------------------
module kv_max_tracker
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_init,
    input  logic             i_update,
    input  EXPMUL_DIFF_IN_QT i_score,
    output EXPMUL_DIFF_IN_QT o_m_run,
    output EXPMUL_DIFF_IN_QT o_m_next
);

    EXPMUL_DIFF_IN_QT r_m_run;

    // Strict greater-than: on a tie the stored max is kept, so m_out equals
    // m_prev_out and expmul's rescale factor is exp(0) = 1.
    assign o_m_next = (i_score > r_m_run) ? i_score : r_m_run;
    assign o_m_run  = r_m_run;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset || i_init) begin
            r_m_run <= M_NEG_INIT;
        end else if (i_update) begin
            r_m_run <= o_m_next;
        end
    end

endmodule

// File: rtl/expmul_kv_sched.sv
// -----------------------------------------------------------------------------
// expmul_kv_sched
//   Sequences the KV score stream of one query row into the expmul datapath.
//   Latches the row length, tracks the running max m and previous max m_prev,
//   tags each beat first/last and registers it towards expmul (one output
//   register, one-cycle latency, full throughput). After the last beat it waits
//   for expmul's row result and then pulses row_done.
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   row_start, seq_len_in start a row (IDLE only); length clamped to 1..MAX_SEQ
//   vld_in, rdy_out, s_in upstream score beat handshake
//   vld_out, rdy_in       downstream (expmul) beat handshake
//   s_out, m_out,
//   m_prev_out            registered score, max including it, max before it
//   first_out, last_out   beat is key 0 / key seq_len-1
//   row_res_in            expmul row result accepted (honoured in FLUSH only)
//   busy, row_done        state != IDLE; one-cycle pulse at row completion
// Configuration:
//   EXPMUL_KV_SCHED_PERF_EN  adds saturating stall_cnt (vld_out && !rdy_in
//                            cycles) and beat_cnt (accepted beats), both
//                            cleared by reset only.
// -----------------------------------------------------------------------------
module expmul_kv_sched
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             row_start,
    input  logic [CNT_W-1:0] seq_len_in,
    input  logic             vld_in,
    output logic             rdy_out,
    input  EXPMUL_DIFF_IN_QT s_in,
    output logic             vld_out,
    input  logic             rdy_in,
    output EXPMUL_DIFF_IN_QT s_out,
    output EXPMUL_DIFF_IN_QT m_out,
    output EXPMUL_DIFF_IN_QT m_prev_out,
    output logic             first_out,
    output logic             last_out,
    input  logic             row_res_in,
    output logic             busy,
    output logic             row_done
`ifdef EXPMUL_KV_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      beat_cnt
`endif
);

    KV_SCHED_STATE_T  r_state;
    logic [CNT_W-1:0] r_seq_len;
    logic [CNT_W-1:0] r_kv_idx;

    logic             r_vld_out;
    logic             r_first;
    logic             r_last;
    logic             r_row_done;
    EXPMUL_DIFF_IN_QT r_s;
    EXPMUL_DIFF_IN_QT r_m;
    EXPMUL_DIFF_IN_QT r_m_prev;

    logic             w_accept;
    logic             w_is_first;
    logic             w_is_last;
    logic             w_row_init;
    EXPMUL_DIFF_IN_QT w_m_run;
    EXPMUL_DIFF_IN_QT w_m_next;

    // Upstream may push whenever the output register is empty or being drained
    // this same cycle, which gives one beat per cycle under continuous flow.
    assign rdy_out    = (r_state == STREAM) && (!r_vld_out || rdy_in);
    assign w_accept   = vld_in && rdy_out;
    assign w_is_first = (r_kv_idx == '0);
    assign w_is_last  = (r_kv_idx == r_seq_len - CNT_W'(1));
    assign w_row_init = (r_state == IDLE) && row_start;

    kv_max_tracker u_max (
        .clock    (clock),
        .reset    (reset),
        .i_init   (w_row_init),
        .i_update (w_accept),
        .i_score  (s_in),
        .o_m_run  (w_m_run),
        .o_m_next (w_m_next)
    );

    // Row sequencing: length latch, key index and state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_seq_len  <= CNT_W'(1);
            r_kv_idx   <= '0;
            r_row_done <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (row_start) begin
                        r_state   <= STREAM;
                        r_seq_len <= clamp_seq_len(seq_len_in);
                        r_kv_idx  <= '0;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (w_is_last) begin
                            r_state  <= FLUSH;
                            r_kv_idx <= '0;
                        end else begin
                            r_kv_idx <= r_kv_idx + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (row_res_in) begin
                        r_state    <= IDLE;
                        r_row_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output register: loads on accept, otherwise holds while stalled and
    // empties once expmul takes the beat. It keeps draining in FLUSH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_out <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_s       <= M_NEG_INIT;
            r_m       <= M_NEG_INIT;
            r_m_prev  <= M_NEG_INIT;
        end else if (w_accept) begin
            r_vld_out <= 1'b1;
            r_first   <= w_is_first;
            r_last    <= w_is_last;
            r_s       <= s_in;
            r_m       <= w_m_next;
            r_m_prev  <= w_m_run;
        end else if (r_vld_out && rdy_in) begin
            r_vld_out <= 1'b0;
        end
    end

    assign vld_out    = r_vld_out;
    assign first_out  = r_first;
    assign last_out   = r_last;
    assign s_out      = r_s;
    assign m_out      = r_m;
    assign m_prev_out = r_m_prev;
    assign busy       = (r_state != IDLE);
    assign row_done   = r_row_done;

`ifdef EXPMUL_KV_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_beat_cnt;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (r_vld_out && !rdy_in && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign beat_cnt  = r_beat_cnt;
`endif

endmodule

// File: tb/tb_expmul_kv_sched.sv
// -----------------------------------------------------------------------------
// tb_expmul_kv_sched
//   Self-checking bench for expmul_kv_sched. Expected beats come from a row
//   model: m_out[k] is the maximum of scores 0..k, m_prev_out[k] is the
//   maximum of scores 0..k-1 (most-negative value for k = 0).
//   Compile with EXPMUL_KV_SCHED_PERF_EN to also check the perf counters.
// -----------------------------------------------------------------------------
module tb_expmul_kv_sched;
    import sys_defs::*;

    localparam int TB_MIN = -(2 ** (DIFF_W - 1));

    logic             clock = 1'b0;
    logic             reset;
    logic             row_start;
    logic [CNT_W-1:0] seq_len_in;
    logic             vld_in;
    logic             rdy_out;
    EXPMUL_DIFF_IN_QT s_in;
    logic             vld_out;
    logic             rdy_in;
    EXPMUL_DIFF_IN_QT s_out;
    EXPMUL_DIFF_IN_QT m_out;
    EXPMUL_DIFF_IN_QT m_prev_out;
    logic             first_out;
    logic             last_out;
    logic             row_res_in;
    logic             busy;
    logic             row_done;
`ifdef EXPMUL_KV_SCHED_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      beat_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int exp_stall = 0;
    int exp_beats = 0;

    int sc   [MAX_SEQ];
    int em   [MAX_SEQ];
    int emp  [MAX_SEQ];
    int dir_s[MAX_SEQ];

    always #5 clock = ~clock;

    expmul_kv_sched dut (
        .clock      (clock),
        .reset      (reset),
        .row_start  (row_start),
        .seq_len_in (seq_len_in),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .s_in       (s_in),
        .vld_out    (vld_out),
        .rdy_in     (rdy_in),
        .s_out      (s_out),
        .m_out      (m_out),
        .m_prev_out (m_prev_out),
        .first_out  (first_out),
        .last_out   (last_out),
        .row_res_in (row_res_in),
        .busy       (busy),
        .row_done   (row_done)
`ifdef EXPMUL_KV_SCHED_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .beat_cnt   (beat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    // Row model: prefix maxima of the score list.
    function automatic void model_row(input int n);
        for (int k = 0; k < n; k++) begin
            int mx = TB_MIN;
            for (int j = 0; j <= k; j++) begin
                if (sc[j] > mx) mx = sc[j];
            end
            em[k]  = mx;
            emp[k] = (k == 0) ? TB_MIN : em[k-1];
        end
    endfunction

    task automatic check_beat(input int k, input int n);
        check($sformatf("s_out[%0d]", k),      s_out,      sc[k]);
        check($sformatf("m_out[%0d]", k),      m_out,      em[k]);
        check($sformatf("m_prev_out[%0d]", k), m_prev_out, emp[k]);
        check($sformatf("first_out[%0d]", k),  first_out,  (k == 0));
        check($sformatf("last_out[%0d]", k),   last_out,   (k == n - 1));
    endtask

    task automatic check_perf();
`ifdef EXPMUL_KV_SCHED_PERF_EN
        check("stall_cnt", stall_cnt, exp_stall);
        check("beat_cnt",  beat_cnt,  exp_beats);
`endif
    endtask

    // One full row: start, stream (optional stall / bursty upstream / ignored
    // control noise), drain, FLUSH, row result, row_done.
    task automatic run_row(input int len_in, input int stall_beat, input int stall_cycles,
                           input bit rand_vld, input bit noise, input bit use_dir);
        int n, in_idx, out_idx, stall_left, cyc, first_acc, last_acc;
        n = (len_in == 0) ? 1 : ((len_in > MAX_SEQ) ? MAX_SEQ : len_in);
        for (int k = 0; k < n; k++) begin
            if (use_dir) begin
                sc[k] = dir_s[k];
            end else begin
                case ($urandom_range(0, 4))
                    0:       sc[k] = (k > 0) ? sc[k-1] : TB_MIN;
                    1:       sc[k] = TB_MIN;
                    default: sc[k] = int'($urandom_range(0, 65535)) + TB_MIN;
                endcase
            end
        end
        model_row(n);

        @(negedge clock);
        row_start  = 1'b1;
        seq_len_in = CNT_W'(len_in);
        vld_in     = 1'b0;
        rdy_in     = 1'b1;
        @(posedge clock);

        in_idx = 0; out_idx = 0; stall_left = stall_cycles; cyc = 0;
        first_acc = -1; last_acc = -1;
        while (out_idx < n && cyc < 400) begin
            @(negedge clock);
            row_start  = 1'b0;
            row_res_in = 1'b0;
            rdy_in = !(out_idx == stall_beat && stall_left > 0);
            vld_in = (in_idx < n) && (!rand_vld || $urandom_range(0, 2) != 0);
            s_in   = vld_in ? EXPMUL_DIFF_IN_QT'(sc[in_idx]) : EXPMUL_DIFF_IN_QT'($urandom);
            if (noise && in_idx < n) begin
                row_start  = cyc[0];
                row_res_in = !cyc[0];
                seq_len_in = CNT_W'($urandom);
            end
            #1;
            if (vld_out && rdy_in) begin
                check_beat(out_idx, n);
                out_idx++;
            end else if (vld_out) begin
                stall_left--;
                exp_stall++;
                check("stall_rdy_out", rdy_out, 1'b0);
                check("stall_s_out",   s_out,   sc[out_idx]);
                check("stall_m_out",   m_out,   em[out_idx]);
            end
            if (vld_in && rdy_out) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                in_idx++;
                exp_beats++;
            end
            cyc++;
            @(posedge clock);
        end
        check("row_beats_delivered", out_idx, n);
        check("row_beats_accepted",  in_idx,  n);
        if (stall_cycles == 0 && !rand_vld) begin
            check("throughput_cycles", last_acc - first_acc + 1, n);
        end

        // FLUSH: upstream held off even while it offers data.
        @(negedge clock);
        vld_in = 1'b1;
        row_start = 1'b0;
        row_res_in = 1'b0;
        #1;
        check("flush_busy",    busy,    1'b1);
        check("flush_rdy_out", rdy_out, 1'b0);
        check("flush_vld_out", vld_out, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clock);
        @(negedge clock);
        row_res_in = 1'b1;
        @(posedge clock);
        @(negedge clock);
        row_res_in = 1'b0;
        vld_in     = 1'b0;
        check("row_done_pulse", row_done, 1'b1);
        check("idle_busy",      busy,     1'b0);
        @(posedge clock);
        @(negedge clock);
        check("row_done_clear", row_done, 1'b0);
        check("idle_vld_out",   vld_out,  1'b0);
        check_perf();
    endtask

    initial begin
        reset = 1'b1; row_start = 1'b0; seq_len_in = '0; vld_in = 1'b0;
        s_in = '0; rdy_in = 1'b1; row_res_in = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_vld_out",    vld_out,    1'b0);
        check("rst_first_out",  first_out,  1'b0);
        check("rst_last_out",   last_out,   1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_row_done",   row_done,   1'b0);
        check("rst_rdy_out",    rdy_out,    1'b0);
        check("rst_s_out",      s_out,      TB_MIN);
        check("rst_m_out",      m_out,      TB_MIN);
        check("rst_m_prev_out", m_prev_out, TB_MIN);
        reset = 1'b0;
        check_perf();

        // Directed rows.
        dir_s[0] = 3; dir_s[1] = -1; dir_s[2] = 7; dir_s[3] = 7;
        run_row(4, -1, 0, 1'b0, 1'b0, 1'b1);
        dir_s[0] = 5;
        run_row(1, -1, 0, 1'b0, 1'b0, 1'b1);
        run_row(3, 1, 4, 1'b0, 1'b0, 1'b0);
        run_row(MAX_SEQ, -1, 0, 1'b0, 1'b0, 1'b0);

        // Reset while beat 2 of 4 is being accepted.
        @(negedge clock);
        row_start = 1'b1; seq_len_in = CNT_W'(4); vld_in = 1'b0; rdy_in = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            row_start = 1'b0;
            vld_in    = 1'b1;
            s_in      = EXPMUL_DIFF_IN_QT'($urandom);
            if (k == 2) reset = 1'b1;
            @(posedge clock);
        end
        @(negedge clock);
        check("midrst_vld_out",  vld_out,  1'b0);
        check("midrst_busy",     busy,     1'b0);
        check("midrst_row_done", row_done, 1'b0);
        check("midrst_rdy_out",  rdy_out,  1'b0);
        reset = 1'b0; vld_in = 1'b0;
        exp_stall = 0; exp_beats = 0;
        run_row(4, -1, 0, 1'b0, 1'b0, 1'b0);

        // Ignored control during STREAM, and length clamping.
        run_row(5, -1, 0, 1'b0, 1'b1, 1'b0);
        run_row(0, -1, 0, 1'b0, 1'b0, 1'b0);
        run_row((1 << CNT_W) - 1, -1, 0, 1'b0, 1'b0, 1'b0);

        // Randomised rows.
        for (int r = 0; r < 12; r++) begin
            run_row($urandom_range(1, MAX_SEQ), $urandom_range(0, MAX_SEQ - 1),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
